// File: rtl/led_cmd_sequencer.sv
// led_cmd_sequencer: HPS command-driven LED sequencer with watchdog heartbeat fallback
module led_cmd_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int WDOG_TICKS = 2000,
  parameter int HB_TICKS   = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pio_cmd,
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic [2:0]  state,
  output logic        led
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(WDOG_TICKS + 2);
  localparam int HW = HB_TICKS > 1 ? $clog2(HB_TICKS) : 1;
  typedef enum logic [2:0] {S_OFF, S_ON, S_BLINK, S_PWM, S_FALLBACK} state_t;
  state_t st, st_nx;
  logic [31:0] cmd_q;
  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] wdog;
  logic [HW-1:0] hb_phase;
  logic [19:0] period_q, on_ticks, phase, on_nx;
  logic [7:0] duty_q, pwm_cnt;
  logic tick, accept, valid, wdog_fire, led_nx;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign accept = cmd_q[31] ^ cmd_ack;
  assign valid = !cmd_q[30] && !(cmd_q[29:28] == 2'd2 && cmd_q[19:0] == 20'd0);
  assign on_nx = 20'((28'(cmd_q[19:0]) * 28'(cmd_q[27:20])) >> 8);
  assign wdog_fire = WDOG_TICKS != 0 && tick && !accept && st != S_FALLBACK && wdog == WW'(WDOG_TICKS - 1);
  assign state = st;
  // mode register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) st <= S_OFF;
    else st <= st_nx;
  // valid commands select their mode, watchdog expiry forces fallback; LED drive derives from current mode
  always_comb begin
    st_nx = st;
    if (accept && valid) st_nx = state_t'({1'b0, cmd_q[29:28]});
    else if (wdog_fire) st_nx = S_FALLBACK;
    led_nx = st == S_ON
      || (st == S_BLINK && (duty_q == 8'hff || phase < on_ticks))
      || (st == S_PWM && (duty_q == 8'hff || pwm_cnt < duty_q))
      || (st == S_FALLBACK && hb_phase < HW'(HB_TICKS / 2));
  end
  // command capture, handshake, prescaler and pattern counters; an accept overrides a same-cycle tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      led <= 1'b0;
      tick_cnt <= '0;
      wdog <= '0;
      hb_phase <= '0;
      period_q <= '0;
      on_ticks <= '0;
      phase <= '0;
      duty_q <= '0;
      pwm_cnt <= '0;
    end else begin
      cmd_q <= pio_cmd;
      led <= led_nx;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (tick) hb_phase <= wdog_fire || hb_phase == HW'(HB_TICKS - 1) ? '0 : hb_phase + 1'b1;
      if (accept) begin
        cmd_ack <= cmd_q[31];
        cmd_err <= !valid;
        wdog <= '0;
        if (valid) begin
          duty_q <= cmd_q[27:20];
          period_q <= cmd_q[19:0];
          on_ticks <= on_nx;
          phase <= '0;
        end
      end else if (tick) begin
        wdog <= wdog == WW'(WDOG_TICKS) ? wdog : wdog + 1'b1;
        if (st == S_BLINK) phase <= phase == period_q - 20'd1 ? '0 : phase + 20'd1;
      end
    end
  end
endmodule
